// File: rtl/branch_predictor_btb.sv
// Direct-mapped, tagged branch target buffer with saturating direction counters.
// Optional BTB_STATS_EN adds resolve/mispredict statistic counters.
module branch_predictor_btb #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned WORD_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [WORD_W-1:0] res_pc,
  input  logic              res_is_jump,
  input  logic              res_taken,
  input  logic [WORD_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [WORD_W-1:0] res_pred_target,
  input  logic              inval_all,
`ifdef BTB_STATS_EN
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispred,
`endif
  output logic              mispredict,
  output logic [WORD_W-1:0] redirect_pc
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [WORD_W-1:0]   r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_res_idx;
  logic [TAG_W-1:0] w_res_tag;
  logic             w_res_hit;
  logic             w_res_taken;
  logic             w_mispredict;
  logic             w_unused;

  assign w_lk_idx  = lookup_pc[IDX_W+1:2];
  assign w_lk_tag  = lookup_pc[WORD_W-1:IDX_W+2];
  assign w_res_idx = res_pc[IDX_W+1:2];
  assign w_res_tag = res_pc[WORD_W-1:IDX_W+2];
  assign w_unused  = ^{lookup_pc[1:0], res_pc[1:0]};

  // Zero-latency lookup against the pre-update table contents
  assign pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign pred_taken  = pred_hit && r_ctr[w_lk_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? r_target[w_lk_idx] : lookup_pc + WORD_W'(4);

  assign w_res_hit   = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
  assign w_res_taken = res_taken || res_is_jump;

  assign w_mispredict = res_valid &&
                        ((res_taken != res_pred_taken) ||
                         (res_taken && (res_target != res_pred_target)));
  assign mispredict   = w_mispredict;
  assign redirect_pc  = !w_mispredict ? '0 :
                        res_taken     ? res_target : res_pc + WORD_W'(4);

  // Table training; invalidate wins over a same-cycle update
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (inval_all) begin
      r_valid <= '0;
    end else if (res_valid) begin
      if (w_res_hit) begin
        if (res_is_jump) begin
          r_ctr[w_res_idx]    <= CTR_MAX;
          r_target[w_res_idx] <= res_target;
        end else if (res_taken) begin
          if (r_ctr[w_res_idx] != CTR_MAX) r_ctr[w_res_idx] <= r_ctr[w_res_idx] + CTR_BITS'(1);
          r_target[w_res_idx] <= res_target;
        end else if (r_ctr[w_res_idx] != '0) begin
          r_ctr[w_res_idx] <= r_ctr[w_res_idx] - CTR_BITS'(1);
        end
      end else if (w_res_taken) begin
        r_valid[w_res_idx]  <= 1'b1;
        r_tag[w_res_idx]    <= w_res_tag;
        r_target[w_res_idx] <= res_target;
        r_ctr[w_res_idx]    <= res_is_jump ? CTR_MAX : CTR_WEAK;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] r_stat_resolved;
  logic [31:0] r_stat_mispred;

  // Saturating event counters, cleared together with the table
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else if (inval_all) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (res_valid && (r_stat_resolved != '1)) r_stat_resolved <= r_stat_resolved + 32'd1;
      if (w_mispredict && (r_stat_mispred != '1)) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_resolved = r_stat_resolved;
  assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (ENTRIES=16, CTR_BITS=2, WORD_W=32).
// Define BTB_STATS_EN for both files to exercise the statistics counters.
module tb_branch_predictor_btb;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_is_jump;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        inval_all;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BTB_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor_btb #(.ENTRIES(16), .CTR_BITS(2), .WORD_W(32)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_is_jump     (res_is_jump),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .inval_all       (inval_all),
`ifdef BTB_STATS_EN
    .stat_resolved   (stat_resolved),
    .stat_mispred    (stat_mispred),
`endif
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic jmp, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    res_valid       = v;
    res_pc          = pc;
    res_is_jump     = jmp;
    res_taken       = tk;
    res_target      = tgt;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    check({tag, "_hit"}, 32'(pred_hit), 32'(hit));
    check({tag, "_taken"}, 32'(pred_taken), 32'(tk));
    check({tag, "_target"}, pred_target, tgt);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic jmp, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic exp_mp, input logic [31:0] exp_rd);
    set_res(1'b1, pc, jmp, tk, tgt, ptk, ptgt);
    #1;
    check({tag, "_mispredict"}, 32'(mispredict), 32'(exp_mp));
    check({tag, "_redirect"}, redirect_pc, exp_rd);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    nRST      = 1'b0;
    inval_all = 1'b0;
    lookup_pc = 32'h100;
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("rst_hit", 32'(pred_hit), 32'h0);
    check("rst_taken", 32'(pred_taken), 32'h0);
    check("rst_target", pred_target, 32'h104);
    check("rst_mispredict", 32'(mispredict), 32'h0);
    check("rst_redirect", redirect_pc, 32'h0);
    #11 nRST = 1'b1;
    tick();

    // Miss, taken: allocate weakly taken
    resolve("alloc", 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
    look("alloc_look", 32'h100, 1'b1, 1'b1, 32'h200);

    // Not-taken training 2 -> 1 -> 0
    resolve("nt1", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
    look("nt1_look", 32'h100, 1'b1, 1'b0, 32'h104);
    resolve("nt2", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h0);
    look("nt2_look", 32'h100, 1'b1, 1'b0, 32'h104);
    resolve("nt3", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h0);
    look("nt_floor", 32'h100, 1'b1, 1'b0, 32'h104);

    // Taken streak 0 -> 1 -> 2 -> 3 -> 3, then one not-taken leaves it taken
    resolve("tk1", 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
    look("tk1_look", 32'h100, 1'b1, 1'b0, 32'h104);
    resolve("tk2", 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
    resolve("tk3", 32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
    resolve("tk_badtgt", 32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h180, 1'b1, 32'h200);
    resolve("sat_nt", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
    look("sat_look", 32'h100, 1'b1, 1'b1, 32'h200);

    // Aliasing jump at 0x140 evicts the 0x100 entry
    resolve("jmp", 32'h140, 1'b1, 1'b1, 32'h300, 1'b0, 32'h144, 1'b1, 32'h300);
    look("evict_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("evict_new", 32'h140, 1'b1, 1'b1, 32'h300);

    // Miss and not taken: no allocation
    resolve("miss_nt", 32'h208, 1'b0, 1'b0, 32'h0, 1'b0, 32'h20c, 1'b0, 32'h0);
    look("miss_nt_look", 32'h208, 1'b0, 1'b0, 32'h20c);

    // Fall-through redirect wraps modulo 2^32
    resolve("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h0);

    // Same-cycle update and lookup at one index: lookup sees old contents
    lookup_pc = 32'h180;
    set_res(1'b1, 32'h180, 1'b1, 1'b1, 32'h400, 1'b0, 32'h184);
    #1;
    check("bypass_hit", 32'(pred_hit), 32'h0);
    check("bypass_target", pred_target, 32'h184);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("after_upd", 32'h180, 1'b1, 1'b1, 32'h400);

    // inval_all beats a same-cycle allocation; mispredict still reported
    inval_all = 1'b1;
    set_res(1'b1, 32'h204, 1'b1, 1'b1, 32'h500, 1'b0, 32'h208);
    #1;
    check("inval_mispredict", 32'(mispredict), 32'h1);
    check("inval_redirect", redirect_pc, 32'h500);
    tick();
    inval_all = 1'b0;
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("inval_a", 32'h180, 1'b0, 1'b0, 32'h184);
    look("inval_b", 32'h204, 1'b0, 1'b0, 32'h208);

    // Asynchronous reset between edges clears valid immediately
    resolve("pre_rst", 32'h300, 1'b1, 1'b1, 32'h600, 1'b0, 32'h304, 1'b1, 32'h600);
    look("pre_rst_look", 32'h300, 1'b1, 1'b1, 32'h600);
    #2 nRST = 1'b0;
    #1;
    check("async_rst_hit", 32'(pred_hit), 32'h0);
    check("async_rst_target", pred_target, 32'h304);
    #3 nRST = 1'b1;
    tick();

`ifdef BTB_STATS_EN
    // 10 resolves, first 3 mispredicted, then reset clears
    for (int i = 0; i < 10; i++) begin
      set_res(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'h0, (i < 3), 32'h0);
      tick();
    end
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stat_resolved", stat_resolved, 32'd10);
    check("stat_mispred", stat_mispred, 32'd3);
    #2 nRST = 1'b0;
    #1;
    check("stat_resolved_rst", stat_resolved, 32'd0);
    check("stat_mispred_rst", stat_mispred, 32'd0);
    #3 nRST = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
